// File: rtl/ddr_request_arbiter_if.sv
// Signal bundle between ddr_request_arbiter, its two requesters and the DDR controller.
// master: the arbiter; slave: requesters plus controller.
interface ddr_request_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int BANK_W = 2
);
  logic              DevReady;

  logic              A_Req, A_Write, A_Ack, A_Done;
  logic [BANK_W-1:0] A_Bank;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_WData, A_RData;

  logic              B_Req, B_Write, B_Ack, B_Done;
  logic [BANK_W-1:0] B_Bank;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_WData, B_RData;

  logic              CtrlWrStart, CtrlRdStart, CtrlRefStart;
  logic [BANK_W-1:0] CtrlBank;
  logic [ADDR_W-1:0] CtrlAddr;
  logic [DATA_W-1:0] CtrlWData;
  logic              CtrlWrReady, CtrlRdReady, CtrlRefReady;
  logic [DATA_W-1:0] CtrlRdData;

  logic              ErrTimeout, RefMissed;

  modport master (
    input  DevReady,
    input  A_Req, A_Write, A_Bank, A_Addr, A_WData,
    output A_Ack, A_Done, A_RData,
    input  B_Req, B_Write, B_Bank, B_Addr, B_WData,
    output B_Ack, B_Done, B_RData,
    output CtrlWrStart, CtrlRdStart, CtrlRefStart, CtrlBank, CtrlAddr, CtrlWData,
    input  CtrlWrReady, CtrlRdReady, CtrlRefReady, CtrlRdData,
    output ErrTimeout, RefMissed
  );

  modport slave (
    output DevReady,
    output A_Req, A_Write, A_Bank, A_Addr, A_WData,
    input  A_Ack, A_Done, A_RData,
    output B_Req, B_Write, B_Bank, B_Addr, B_WData,
    input  B_Ack, B_Done, B_RData,
    input  CtrlWrStart, CtrlRdStart, CtrlRefStart, CtrlBank, CtrlAddr, CtrlWData,
    output CtrlWrReady, CtrlRdReady, CtrlRefReady, CtrlRdData,
    input  ErrTimeout, RefMissed
  );
endinterface

// File: rtl/ddr_request_arbiter.sv
// Two-port DDR front-end scheduler: arbitration, refresh timer, Ready timeout, one op in flight.
// Define DDR_ARB_FIXED_PRIO_EN to make port A win every tie instead of round-robin.
module ddr_request_arbiter #(
  parameter int ADDR_W           = 23,
  parameter int DATA_W           = 16,
  parameter int BANK_W           = 2,
  parameter int REFRESH_INTERVAL = 1500,
  parameter int TIMEOUT          = 255
) (
  input logic                   CLK_200MHz,
  input logic                   WrStart,
  ddr_request_arbiter_if.master bus
);
  localparam int RC_W = $clog2(REFRESH_INTERVAL);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_REF} op_t;

  state_t          state;
  op_t             op;
  logic            own_b;
  logic            last_b;
  logic [RC_W-1:0] ref_cnt;
  logic            ref_pending;
  logic [TO_W-1:0] wait_cnt;
  logic [2:0]      rdy_q, rdy_qq;  // {ref, rd, wr}
  logic            ready_rise;
  logic            grant_a, grant_b;

  always_ff @(posedge CLK_200MHz or posedge WrStart) begin
    if (WrStart) begin
      rdy_q  <= '0;
      rdy_qq <= '0;
    end else begin
      rdy_q  <= {bus.CtrlRefReady, bus.CtrlRdReady, bus.CtrlWrReady};
      rdy_qq <= rdy_q;
    end
  end

  always_comb begin
    case (op)
      OP_WR:   ready_rise = rdy_q[0] & ~rdy_qq[0];
      OP_RD:   ready_rise = rdy_q[1] & ~rdy_qq[1];
      default: ready_rise = rdy_q[2] & ~rdy_qq[2];
    endcase
  end

  always_comb begin
`ifdef DDR_ARB_FIXED_PRIO_EN
    grant_a = bus.A_Req;
`else
    grant_a = bus.A_Req & (~bus.B_Req | last_b);
`endif
    grant_b = bus.B_Req & ~grant_a;
  end

  always_ff @(posedge CLK_200MHz or posedge WrStart) begin
    if (WrStart) begin
      state            <= IDLE;
      op               <= OP_WR;
      own_b            <= 1'b0;
      last_b           <= 1'b1;
      ref_cnt          <= '0;
      ref_pending      <= 1'b0;
      wait_cnt         <= '0;
      bus.A_Ack        <= 1'b0;
      bus.B_Ack        <= 1'b0;
      bus.A_Done       <= 1'b0;
      bus.B_Done       <= 1'b0;
      bus.A_RData      <= '0;
      bus.B_RData      <= '0;
      bus.CtrlWrStart  <= 1'b0;
      bus.CtrlRdStart  <= 1'b0;
      bus.CtrlRefStart <= 1'b0;
      bus.CtrlBank     <= '0;
      bus.CtrlAddr     <= '0;
      bus.CtrlWData    <= '0;
      bus.ErrTimeout   <= 1'b0;
      bus.RefMissed    <= 1'b0;
    end else begin
      bus.A_Ack  <= 1'b0;
      bus.B_Ack  <= 1'b0;
      bus.A_Done <= 1'b0;
      bus.B_Done <= 1'b0;

      case (state)
        IDLE: if (bus.DevReady) begin
          if (ref_pending) begin
            ref_pending      <= 1'b0;
            op               <= OP_REF;
            bus.CtrlRefStart <= 1'b1;
            wait_cnt         <= '0;
            state            <= WAIT;
          end else if (grant_a || grant_b) begin
            bus.A_Ack     <= grant_a;
            bus.B_Ack     <= grant_b;
            own_b         <= grant_b;
            last_b        <= grant_b;
            bus.CtrlBank  <= grant_b ? bus.B_Bank  : bus.A_Bank;
            bus.CtrlAddr  <= grant_b ? bus.B_Addr  : bus.A_Addr;
            bus.CtrlWData <= grant_b ? bus.B_WData : bus.A_WData;
            op            <= (grant_b ? bus.B_Write : bus.A_Write) ? OP_WR : OP_RD;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.CtrlWrStart <= (op == OP_WR);
          bus.CtrlRdStart <= (op == OP_RD);
          wait_cnt        <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          if (ready_rise || wait_cnt == TO_W'(TIMEOUT - 1)) begin
            bus.CtrlWrStart  <= 1'b0;
            bus.CtrlRdStart  <= 1'b0;
            bus.CtrlRefStart <= 1'b0;
            if (!ready_rise) bus.ErrTimeout <= 1'b1;
            // Timed-out requesters still get Done so they never stall; RData stays stale.
            if (op != OP_REF) begin
              bus.A_Done <= ~own_b;
              bus.B_Done <= own_b;
            end
            if (ready_rise && op == OP_RD) begin
              if (own_b) bus.B_RData <= bus.CtrlRdData;
              else       bus.A_RData <= bus.CtrlRdData;
            end
            state <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RELEASE: if (rdy_q == 3'b000) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a wrap in the grant cycle re-arms the next refresh.
      if (ref_cnt == RC_W'(REFRESH_INTERVAL - 1)) begin
        ref_cnt     <= '0;
        ref_pending <= 1'b1;
        if (ref_pending) bus.RefMissed <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end
endmodule
